// File: rtl/mux_tt_pkg.sv
// Shared types and helpers for the 2:1 mux truth-table sequencer.
package mux_tt_pkg;

  localparam int unsigned NUM_VEC    = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned MAX_NODE_W = 32;
  localparam int unsigned MAX_REC_W  = IDX_W + MAX_NODE_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRIVE     = 3'd1,
    SEND      = 3'd2,
    WAIT_STEP = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Node vector is zero-extended to MAX_NODE_W; callers truncate to IDX_W+node_w.
  function automatic logic [MAX_REC_W-1:0] pack_record(
    input logic [IDX_W-1:0]      idx,
    input logic [MAX_NODE_W-1:0] node,
    input int unsigned           node_w
  );
    return (MAX_REC_W'(idx) << node_w) | MAX_REC_W'(node);
  endfunction

endpackage

// File: rtl/mux_tt_checker.sv
// Golden compare of the captured mux output against S ? I1 : I0, with a
// sticky mismatch flag and a saturating 4-bit error counter.
module mux_tt_checker
  import mux_tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             capture,
  input  logic [IDX_W-1:0] idx,
  input  logic             out_bit,
  output logic             mismatch,
  output logic [3:0]       err_count
);

  logic       mismatch_q, mismatch_d;
  logic [3:0] err_q, err_d;
  logic       golden;

  always_comb begin
    golden     = idx[2] ? idx[1] : idx[0];
    mismatch_d = mismatch_q;
    err_d      = err_q;
    if (clear) begin
      mismatch_d = 1'b0;
      err_d      = '0;
    end else if (capture && (out_bit != golden)) begin
      mismatch_d = 1'b1;
      if (err_q != '1) err_d = err_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign mismatch  = mismatch_q;
  assign err_count = err_q;

endmodule

// File: rtl/mux_tt_sequencer.sv
// Sweeps {S,I1,I0} through all eight vectors, captures the node vector after
// HOLD_CYCLES and emits one record per vector. Optional checker: MUX_TT_CHECK_EN.
module mux_tt_sequencer
  import mux_tt_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned NODE_W      = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    step_mode,
  input  logic                    step,
  output logic                    S,
  output logic                    I0,
  output logic                    I1,
  input  logic [NODE_W-1:0]       node_in,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [IDX_W+NODE_W-1:0] rec_data,
  output logic                    busy,
  output logic                    done
`ifdef MUX_TT_CHECK_EN
  ,
  output logic                    mismatch,
  output logic [3:0]              err_count
`endif
);

  localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_VEC - 1);

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic                      step_lat_q, step_lat_d;
  logic [IDX_W+NODE_W-1:0]   rec_q, rec_d;
  logic                      capture;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    step_lat_d = step_lat_q;
    rec_d      = rec_q;
    capture    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = DRIVE;
          idx_d      = '0;
          hold_d     = '0;
          step_lat_d = step_mode;
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          capture = 1'b1;
          rec_d   = (IDX_W + NODE_W)'(pack_record(idx_q, MAX_NODE_W'(node_in), NODE_W));
          state_d = SEND;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      SEND: begin
        if (rec_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else if (step_lat_q) begin
            state_d = WAIT_STEP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            hold_d  = '0;
            state_d = DRIVE;
          end
        end
      end
      WAIT_STEP: begin
        if (step) begin
          idx_d   = idx_q + IDX_W'(1);
          hold_d  = '0;
          state_d = DRIVE;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      step_lat_q <= 1'b0;
      rec_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      step_lat_q <= step_lat_d;
      rec_q      <= rec_d;
    end
  end

  assign {S, I1, I0} = idx_q;
  assign rec_valid   = (state_q == SEND);
  assign rec_data    = rec_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

`ifdef MUX_TT_CHECK_EN
  mux_tt_checker u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     ((state_q == IDLE) && start),
    .capture   (capture),
    .idx       (idx_q),
    .out_bit   (node_in[NODE_W-1]),
    .mismatch  (mismatch),
    .err_count (err_count)
  );
`endif

endmodule

// File: tb/tb_mux_tt_sequencer.sv
// Bench for mux_tt_sequencer: gate-level mux model, transaction-level reference,
// and directed sweeps (auto, backpressure, step, faulty model, async reset).
module tb_mux_tt_sequencer;

  localparam int unsigned HOLD  = 4;
  localparam int unsigned NW    = 9;
  localparam int unsigned REC_W = 3 + NW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic step_mode = 1'b0;
  logic step = 1'b0;
  logic rec_ready = 1'b1;
  logic bad_mux = 1'b0;
  logic S, I0, I1, rec_valid, busy, done;
  logic [NW-1:0]    node_in;
  logic [REC_W-1:0] rec_data;
`ifdef MUX_TT_CHECK_EN
  logic       mismatch;
  logic [3:0] err_count;
`endif

  always #5 clk = ~clk;

  // NAND-style 2:1 mux; bad_mux makes the I0 leg behave as if I0 were 1.
  logic i0e, sn, a0, a1, n0, n1;
  always_comb begin
    i0e     = I0 | bad_mux;
    sn      = ~S;
    a0      = i0e & sn;
    a1      = I1 & S;
    n0      = ~a0;
    n1      = ~a1;
    node_in = {~(n0 & n1), n1, n0, a1, a0, sn, S, I1, I0};
  end

  mux_tt_sequencer #(.HOLD_CYCLES(HOLD), .NODE_W(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .S         (S),
    .I0        (I0),
    .I1        (I1),
    .node_in   (node_in),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .busy      (busy),
    .done      (done)
`ifdef MUX_TT_CHECK_EN
    ,
    .mismatch  (mismatch),
    .err_count (err_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: what the sweep should look like at transaction level.
  bit m_busy, waiting, done_pend, m_step, prev_valid;
  int sent, valid_due, start_cyc, done_n;
  int rise_n [8];
`ifdef MUX_TT_CHECK_EN
  int m_err;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [REC_W-1:0] exp_rec(input int i, input logic bad);
    logic [2:0] v;
    logic s, b1, b0, b0e, o, x0, x1;
    v   = 3'(i);
    s   = v[2];
    b1  = v[1];
    b0  = v[0];
    b0e = b0 | bad;
    o   = s ? b1 : b0e;
    x0  = b0e & ~s;
    x1  = b1 & s;
    return {v, o, ~x1, ~x0, x1, x0, ~s, s, b1, b0};
  endfunction

  task automatic monitor_cycle();
    logic [2:0] e_idx;
    bit         e_valid;
    if (!rst_n) begin
      chk("reset_outputs", 32'({S, I1, I0, rec_valid, busy, done}), 32'd0);
      chk("reset_rec_data", 32'(rec_data), 32'd0);
`ifdef MUX_TT_CHECK_EN
      chk("reset_checker", 32'({mismatch, err_count}), 32'd0);
      m_err = 0;
`endif
      m_busy = 0; waiting = 0; done_pend = 0; sent = 0; prev_valid = 0;
      return;
    end
    e_idx   = !m_busy ? 3'd0 : (done_pend ? 3'd7 : (waiting ? 3'(sent - 1) : 3'(sent)));
    e_valid = m_busy && !waiting && !done_pend && (cyc >= valid_due);
`ifdef MUX_TT_CHECK_EN
    if (e_valid && cyc == valid_due && bad_mux && !e_idx[2] && !e_idx[0] && m_err < 15)
      m_err++;
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("mismatch", 32'(mismatch), 32'(m_err != 0));
`endif
    chk("stimulus", 32'({S, I1, I0}), 32'(e_idx));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(done_pend));
    chk("rec_valid", 32'(rec_valid), 32'(e_valid));
    if (e_valid) chk("rec_data", 32'(rec_data), 32'(exp_rec(sent, bad_mux)));
    if (rec_valid && !prev_valid && sent < 8) rise_n[sent] = cyc - start_cyc + 1;
    if (done) done_n = cyc - start_cyc + 1;
    prev_valid = rec_valid;
    // Advance the reference to what the next edge should produce.
    if (done_pend) begin
      m_busy = 0; done_pend = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_step = step_mode; sent = 0; waiting = 0;
        start_cyc = cyc + 1; valid_due = cyc + 1 + HOLD; done_n = -1;
        foreach (rise_n[i]) rise_n[i] = -1;
`ifdef MUX_TT_CHECK_EN
        m_err = 0;
`endif
      end
    end else if (waiting) begin
      if (step) begin
        waiting = 0; valid_due = cyc + 1 + HOLD;
      end
    end else if (e_valid && rec_ready) begin
      sent++;
      if (sent == 8) done_pend = 1;
      else if (m_step) waiting = 1;
      else valid_due = cyc + 1 + HOLD;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic sm);
    start = 1'b1; step_mode = sm;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
    end
    chk(name, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
    join_none

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Auto sweep, ready tied high.
    pulse_start(1'b0);
    wait_done("auto_done_seen", 200);
    for (int i = 0; i < 8; i++) chk("auto_first_valid_cycle", 32'(rise_n[i]), 32'(5 * (i + 1)));
    chk("auto_done_cycle", 32'(done_n), 32'd41);
    chk("auto_record_count", 32'(sent), 32'd8);
`ifdef MUX_TT_CHECK_EN
    chk("auto_err_count", 32'(err_count), 32'd0);
`endif

    // Backpressure on record 3, plus a stray step that must be ignored.
    pulse_start(1'b0);
    n = 0;
    while (!(rec_valid && rec_data[REC_W-1 -: 3] == 3'd3) && n < 100) begin
      tick();
      n++;
    end
    rec_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step = (c == 2);
      tick();
      chk("bp_rec_data", 32'(rec_data), 32'h79B);
      chk("bp_stimulus", 32'({S, I1, I0}), 32'b011);
    end
    step = 1'b0;
    rec_ready = 1'b1;
    wait_done("bp_done_seen", 200);
    chk("bp_record_count", 32'(sent), 32'd8);

    // Step mode, steps every 7 cycles, a start pulse mid-sweep.
    pulse_start(1'b1);
    repeat (5) tick();
    chk("step_wait_state", 32'({rec_valid, busy, S, I1, I0}), 32'b01000);
    for (int v = 1; v < 8; v++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      if (v < 7) begin
        for (int t = 0; t < 6; t++) begin
          start = (v == 3 && t == 0);
          tick();
        end
        start = 1'b0;
      end
    end
    wait_done("step_done_seen", 50);
    chk("step_record_count", 32'(sent), 32'd8);

    // Faulty model: output ignores I0.
    bad_mux = 1'b1;
    pulse_start(1'b0);
    n = 0;
    while (!(rec_valid && rec_data[REC_W-1 -: 3] == 3'd5) && n < 100) begin
      tick();
      n++;
    end
    chk("bad_rec5_data", 32'(rec_data), 32'hAC5);
    wait_done("bad_done_seen", 200);
`ifdef MUX_TT_CHECK_EN
    chk("bad_err_count", 32'(err_count), 32'd2);
    chk("bad_mismatch", 32'(mismatch), 32'd1);
`endif
    bad_mux = 1'b0;

    // Async reset during DRIVE of vector 5.
    pulse_start(1'b0);
`ifdef MUX_TT_CHECK_EN
    chk("restart_clears_err", 32'(err_count), 32'd0);
`endif
    n = 0;
    while (!(busy && !rec_valid && {S, I1, I0} == 3'd5) && n < 100) begin
      tick();
      n++;
    end
    chk("rst_reached_vec5", 32'({S, I1, I0}), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({S, I1, I0, rec_valid, busy, done}), 32'd0);
    chk("async_rst_rec_data", 32'(rec_data), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    pulse_start(1'b0);
    wait_done("post_rst_done_seen", 200);
    chk("post_rst_first_valid", 32'(rise_n[0]), 32'd5);
    chk("post_rst_last_valid", 32'(rise_n[7]), 32'd40);
    chk("post_rst_done_cycle", 32'(done_n), 32'd41);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
